dmem_port_arbiter: RTL and testbench

Parametrised N-port arbiter placed in front of the single-port `dmem` in the processor/VGA top level. It lets the processor, the VGA scan-out reader and a debug or loader port share one synchronous RAM. Arbitration is round-robin or fixed-priority, and each read returns its data one cycle after the grant. The block also records the last accepted write on debug outputs for the grader.

---
 rtl/dmem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: lets NUM_PORTS requesters share one synchronous dmem.
// One winner per cycle (round-robin or fixed priority) drives the memory
// combinationally; read data returns one cycle after the grant. The last
// accepted write and a saturating write count are exposed for debug.
module dmem_port_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter bit RR_MODE   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data,
  output logic                        mem_wren,
  input  logic [DATA_W-1:0]           mem_q,
  output logic [ADDR_W-1:0]           dbg_addr,
  output logic [DATA_W-1:0]           dbg_data,
  output logic [15:0]                 dbg_wr_count
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_rd_port;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_dbg_addr;
  logic [DATA_W-1:0] r_dbg_data;
  logic [15:0]       r_wr_count;

  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_ptr_next;
  logic              w_found;
  logic              w_any;
  logic              w_win_we;

  // Scan requesters starting at the rotating pointer (or at port 0) and take the first hit.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE) begin
        idx = int'(r_ptr) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      end else begin
        idx = k;
      end
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(idx);
      end
    end
  end

  assign w_any      = w_found & reset;
  assign w_win_we   = we[w_win];
  assign w_ptr_next = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;

  // Steer the winner's request onto the memory port; idle drives zeros.
  always_comb begin
    gnt         = '0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    if (w_any) begin
      gnt[w_win]  = 1'b1;
      mem_wren    = w_win_we;
      mem_address = addr[w_win*ADDR_W +: ADDR_W];
      mem_data    = wdata[w_win*DATA_W +: DATA_W];
    end
  end

  // Return dmem's registered q to whichever port read last cycle.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (r_rd_pend) begin
      rvalid[r_rd_port] = 1'b1;
      rdata             = mem_q;
    end
  end

  // Advance the round-robin pointer past each winner and remember pending reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_port <= '0;
    end else begin
      r_rd_pend <= w_any & ~w_win_we;
      if (w_any) begin
        r_ptr     <= w_ptr_next;
        r_rd_port <= w_win;
      end
    end
  end

  // Capture each accepted write and count it, sticking at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dbg_addr <= '0;
      r_dbg_data <= '0;
      r_wr_count <= '0;
    end else if (w_any && w_win_we) begin
      r_dbg_addr <= addr[w_win*ADDR_W +: ADDR_W];
      r_dbg_data <= wdata[w_win*DATA_W +: DATA_W];
      if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign dbg_addr     = r_dbg_addr;
  assign dbg_data     = r_dbg_data;
  assign dbg_wr_count = r_wr_count;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed tests for the dmem port arbiter. A round-robin
// instance is backed by a small synchronous RAM model; a fixed-priority
// instance shares the same request inputs.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req   = '0;
  logic [2:0]  we    = '0;
  logic [35:0] addr  = '0;
  logic [95:0] wdata = '0;

  logic [2:0]  gntRr, gntFp, rvalidRr, rvalidFp;
  logic [31:0] rdataRr, rdataFp, memDataRr, memDataFp;
  logic [11:0] memAddressRr, memAddressFp, dbgAddrRr, dbgAddrFp;
  logic        memWrenRr, memWrenFp;
  logic [31:0] dbgDataRr, dbgDataFp;
  logic [15:0] dbgCountRr, dbgCountFp;
  logic [31:0] memQRr = '0;
  logic [31:0] memQFp = '0;
  logic [31:0] memArr [0:4095];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(12), .DATA_W(32), .RR_MODE(1'b1)) dutRr (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gntRr), .rvalid(rvalidRr), .rdata(rdataRr),
    .mem_address(memAddressRr), .mem_data(memDataRr), .mem_wren(memWrenRr), .mem_q(memQRr),
    .dbg_addr(dbgAddrRr), .dbg_data(dbgDataRr), .dbg_wr_count(dbgCountRr)
  );

  dmem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(12), .DATA_W(32), .RR_MODE(1'b0)) dutFp (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gntFp), .rvalid(rvalidFp), .rdata(rdataFp),
    .mem_address(memAddressFp), .mem_data(memDataFp), .mem_wren(memWrenFp), .mem_q(memQFp),
    .dbg_addr(dbgAddrFp), .dbg_data(dbgDataFp), .dbg_wr_count(dbgCountFp)
  );

  // Single-port synchronous RAM with one-cycle registered read, like dmem.
  always @(posedge clock) begin
    if (memWrenRr) memArr[memAddressRr] <= memDataRr;
    memQRr <= memArr[memAddressRr];
  end

  task automatic setPort(input int p, input logic w, input logic [11:0] a, input logic [31:0] d);
    we[p] = w;
    addr[p*12 +: 12] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    req = '0;
    we = '0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 3'b111;
    we = 3'b101;
    setPort(0, 1'b1, 12'h123, 32'hCAFE0000);
    setPort(2, 1'b1, 12'h456, 32'hCAFE0002);
    @(negedge clock); #1;
    vectors++; if (gntRr !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_gnt_rr: got %b, expected 000", gntRr); end
    vectors++; if (gntFp !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_gnt_fp: got %b, expected 000", gntFp); end
    vectors++; if (memWrenRr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wren: got %b, expected 0", memWrenRr); end
    vectors++; if (memAddressRr !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_addr: got %h, expected 000", memAddressRr); end
    vectors++; if (memDataRr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mdata: got %h, expected 0", memDataRr); end
    vectors++; if (rvalidRr !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_rvalid: got %b, expected 000", rvalidRr); end
    vectors++; if (rdataRr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h, expected 0", rdataRr); end
    vectors++; if (dbgAddrRr !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_dbg_addr: got %h, expected 000", dbgAddrRr); end
    vectors++; if (dbgDataRr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_dbg_data: got %h, expected 0", dbgDataRr); end
    vectors++; if (dbgCountRr !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_dbg_count: got %h, expected 0", dbgCountRr); end
    reset = 1'b1;
    #1;
    vectors++; if (gntRr !== 3'b001) begin miscompares++; $display("[TB] FAIL release_gnt_rr: got %b, expected 001", gntRr); end
    vectors++; if (gntFp !== 3'b001) begin miscompares++; $display("[TB] FAIL release_gnt_fp: got %b, expected 001", gntFp); end
  endtask

  task automatic test_rr_rotation();
    logic [2:0] rrSeq [6];
    logic [2:0] prevGnt;
    rrSeq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    prevGnt = 3'b000;
    doReset();
    req = 3'b111;
    we = 3'b000;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++; if (gntRr !== rrSeq[i]) begin miscompares++; $display("[TB] FAIL rr_gnt[%0d]: got %b, expected %b", i, gntRr, rrSeq[i]); end
      vectors++; if (rvalidRr !== prevGnt) begin miscompares++; $display("[TB] FAIL rr_rvalid[%0d]: got %b, expected %b", i, rvalidRr, prevGnt); end
      prevGnt = rrSeq[i];
      @(negedge clock);
    end
  endtask

  task automatic test_fixed_priority();
    doReset();
    req = 3'b110;
    we = 3'b000;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (gntFp !== 3'b010) begin miscompares++; $display("[TB] FAIL fp_gnt[%0d]: got %b, expected 010", i, gntFp); end
      vectors++; if (gntRr !== ((i % 2 == 0) ? 3'b010 : 3'b100)) begin miscompares++; $display("[TB] FAIL fp_rr_alt[%0d]: got %b", i, gntRr); end
      @(negedge clock);
    end
    req = 3'b100;
    #1;
    vectors++; if (gntFp !== 3'b100) begin miscompares++; $display("[TB] FAIL fp_port2: got %b, expected 100", gntFp); end
    @(negedge clock);
  endtask

  task automatic test_write_then_read();
    doReset();
    req = 3'b001;
    we = 3'b000;
    setPort(0, 1'b1, 12'h001, 32'hDEADBEEF);
    #1;
    vectors++; if (gntRr !== 3'b001) begin miscompares++; $display("[TB] FAIL wr_gnt: got %b, expected 001", gntRr); end
    vectors++; if (memWrenRr !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_wren: got %b, expected 1", memWrenRr); end
    vectors++; if (memAddressRr !== 12'h001) begin miscompares++; $display("[TB] FAIL wr_addr: got %h, expected 001", memAddressRr); end
    vectors++; if (memDataRr !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL wr_mdata: got %h, expected deadbeef", memDataRr); end
    @(negedge clock);
    req = 3'b010;
    we = 3'b000;
    setPort(1, 1'b0, 12'h001, 32'h0);
    #1;
    vectors++; if (dbgAddrRr !== 12'h001) begin miscompares++; $display("[TB] FAIL wr_dbg_addr: got %h, expected 001", dbgAddrRr); end
    vectors++; if (dbgDataRr !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL wr_dbg_data: got %h, expected deadbeef", dbgDataRr); end
    vectors++; if (dbgCountRr !== 16'd1) begin miscompares++; $display("[TB] FAIL wr_dbg_count: got %0d, expected 1", dbgCountRr); end
    vectors++; if (rvalidRr !== 3'b000) begin miscompares++; $display("[TB] FAIL wr_no_rvalid: got %b, expected 000", rvalidRr); end
    vectors++; if (gntRr !== 3'b010) begin miscompares++; $display("[TB] FAIL rd_gnt: got %b, expected 010", gntRr); end
    @(negedge clock);
    req = 3'b000;
    #1;
    vectors++; if (rvalidRr !== 3'b010) begin miscompares++; $display("[TB] FAIL rd_rvalid: got %b, expected 010", rvalidRr); end
    vectors++; if (rdataRr !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL rd_rdata: got %h, expected deadbeef", rdataRr); end
    @(negedge clock);
    #1;
    vectors++; if (rvalidRr !== 3'b000) begin miscompares++; $display("[TB] FAIL rd_pulse_end: got %b, expected 000", rvalidRr); end
  endtask

  task automatic test_back_to_back();
    doReset();
    req = 3'b111;
    we = 3'b000;
    setPort(0, 1'b1, 12'h0A0, 32'h11112222);
    setPort(1, 1'b0, 12'h0A0, 32'h0);
    setPort(2, 1'b1, 12'h0B0, 32'h33334444);
    #1;
    vectors++; if (gntRr !== 3'b001) begin miscompares++; $display("[TB] FAIL b2b_gnt0: got %b, expected 001", gntRr); end
    @(negedge clock); #1;
    vectors++; if (gntRr !== 3'b010) begin miscompares++; $display("[TB] FAIL b2b_gnt1: got %b, expected 010", gntRr); end
    vectors++; if (memWrenRr !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_rd_wren: got %b, expected 0", memWrenRr); end
    @(negedge clock); #1;
    vectors++; if (gntRr !== 3'b100) begin miscompares++; $display("[TB] FAIL b2b_gnt2: got %b, expected 100", gntRr); end
    vectors++; if (rvalidRr !== 3'b010) begin miscompares++; $display("[TB] FAIL b2b_rvalid: got %b, expected 010", rvalidRr); end
    vectors++; if (rdataRr !== 32'h11112222) begin miscompares++; $display("[TB] FAIL b2b_rdata: got %h, expected 11112222", rdataRr); end
    vectors++; if (memWrenRr !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_wr_wren: got %b, expected 1", memWrenRr); end
    @(negedge clock);
    req = 3'b000;
    #1;
    vectors++; if (gntRr !== 3'b000) begin miscompares++; $display("[TB] FAIL b2b_idle_gnt: got %b, expected 000", gntRr); end
    vectors++; if (memAddressRr !== 12'h000) begin miscompares++; $display("[TB] FAIL b2b_idle_addr: got %h, expected 000", memAddressRr); end
    vectors++; if (rvalidRr !== 3'b000) begin miscompares++; $display("[TB] FAIL b2b_wr_rvalid: got %b, expected 000", rvalidRr); end
    vectors++; if (dbgAddrRr !== 12'h0B0) begin miscompares++; $display("[TB] FAIL b2b_dbg_addr: got %h, expected 0b0", dbgAddrRr); end
    vectors++; if (dbgCountRr !== 16'd2) begin miscompares++; $display("[TB] FAIL b2b_dbg_count: got %0d, expected 2", dbgCountRr); end
  endtask

  task automatic test_reset_mid_read();
    doReset();
    req = 3'b001;
    we = 3'b000;
    setPort(0, 1'b1, 12'h010, 32'h00000005);
    #1;
    vectors++; if (gntRr !== 3'b001) begin miscompares++; $display("[TB] FAIL mid_pre_gnt: got %b, expected 001", gntRr); end
    @(negedge clock);
    req = 3'b100;
    we = 3'b000;
    setPort(2, 1'b0, 12'h0A0, 32'h0);
    #1;
    vectors++; if (gntRr !== 3'b100) begin miscompares++; $display("[TB] FAIL mid_rd_gnt: got %b, expected 100", gntRr); end
    #1;
    reset = 1'b0;
    #1;
    vectors++; if (gntRr !== 3'b000) begin miscompares++; $display("[TB] FAIL mid_rst_gnt: got %b, expected 000", gntRr); end
    @(negedge clock); #1;
    vectors++; if (rvalidRr !== 3'b000) begin miscompares++; $display("[TB] FAIL mid_rvalid_rr: got %b, expected 000", rvalidRr); end
    vectors++; if (rvalidFp !== 3'b000) begin miscompares++; $display("[TB] FAIL mid_rvalid_fp: got %b, expected 000", rvalidFp); end
    reset = 1'b1;
    req = 3'b111;
    #1;
    vectors++; if (gntRr !== 3'b001) begin miscompares++; $display("[TB] FAIL mid_ptr_reset: got %b, expected 001", gntRr); end
    vectors++; if (rvalidRr !== 3'b000) begin miscompares++; $display("[TB] FAIL mid_rvalid_after: got %b, expected 000", rvalidRr); end
    @(negedge clock);
  endtask

  task automatic test_saturation();
    logic [11:0] satAddr [3];
    satAddr = '{12'h100, 12'h200, 12'h300};
    doReset();
    req = 3'b001;
    we = 3'b000;
    setPort(0, 1'b1, 12'h055, 32'hA5A5A5A5);
    repeat (65534) @(negedge clock);
    #1;
    vectors++; if (dbgCountRr !== 16'hFFFE) begin miscompares++; $display("[TB] FAIL sat_preload: got %h, expected fffe", dbgCountRr); end
    for (int i = 0; i < 3; i++) begin
      setPort(0, 1'b1, satAddr[i], 32'h5A000000 + i);
      @(negedge clock); #1;
      vectors++; if (dbgCountRr !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_count[%0d]: got %h, expected ffff", i, dbgCountRr); end
    end
    vectors++; if (dbgAddrRr !== 12'h300) begin miscompares++; $display("[TB] FAIL sat_dbg_addr: got %h, expected 300", dbgAddrRr); end
    vectors++; if (dbgDataRr !== 32'h5A000002) begin miscompares++; $display("[TB] FAIL sat_dbg_data: got %h, expected 5a000002", dbgDataRr); end
    req = 3'b000;
    @(negedge clock); #1;
    vectors++; if (dbgCountRr !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_hold: got %h, expected ffff", dbgCountRr); end
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
